// File: rtl/pipe_exe_muldiv.sv
// Iterative multiply/divide unit for the EX stage.
// One shift-add (multiply) or restoring subtract-shift (divide) step per RUN
// cycle on 32-bit magnitudes; signs are restored in FIX and the result is
// published to hi/lo on the FIX->DONE edge.
//
// Handshake: estart is a one-cycle request that is only sampled in IDLE.
// busy is high while an operation occupies RUN or FIX, which stalls the
// requester. done pulses for exactly one cycle (DONE) when hi/lo change.
// eflush squashes any operation at the next edge and is stronger than estart.
module pipe_exe_muldiv (
  input  logic        clock,
  input  logic        resetn,
  input  logic        estart,
  input  logic [1:0]  eop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        eflush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        sa_q, sb_q, dz_q;
  logic [32:0] acc_q;   // product high half / partial remainder
  logic [31:0] q_q;     // multiplier (shifted out) / dividend -> quotient
  logic [31:0] b_q;     // multiplicand / divisor magnitude
  logic [31:0] hi_q, lo_q;
  logic        dbz_q;

  // Operand conditioning at start: magnitudes only for signed operations.
  logic        a_neg, b_neg, start_dz;
  logic [31:0] a_mag, b_mag;
  assign a_neg    = eop[0] & ea[31];
  assign b_neg    = eop[0] & eb[31];
  assign a_mag    = a_neg ? (32'd0 - ea) : ea;
  assign b_mag    = b_neg ? (32'd0 - eb) : eb;
  assign start_dz = eop[1] && (eb == 32'd0);

  // One iteration of either algorithm, selected later by op_q[1].
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  assign mul_sum = acc_q + (q_q[0] ? {1'b0, b_q} : 33'd0);
  assign div_sh  = {acc_q[31:0], q_q[31]};
  assign div_ge  = div_sh >= {1'b0, b_q};

  // Sign correction applied to the raw magnitude result in FIX.
  logic [63:0] prod, fix_res;
  logic [31:0] quo, rem;
  always_comb begin
    prod    = {acc_q[31:0], q_q};
    quo     = q_q;
    rem     = acc_q[31:0];
    fix_res = prod;
    if (dz_q) begin
      fix_res = {acc_q[31:0], q_q};
    end else if (op_q[1]) begin
      if (op_q[0] && (sa_q ^ sb_q)) quo = 32'd0 - q_q;
      if (op_q[0] && sa_q)          rem = 32'd0 - acc_q[31:0];
      fix_res = {rem, quo};
    end else if (op_q[0] && (sa_q ^ sb_q)) begin
      fix_res = 64'd0 - prod;
    end
  end

  // Next-state logic; eflush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (estart) state_d = start_dz ? S_FIX : S_RUN;
      S_RUN:  if (cnt_q == 5'd0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (eflush) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: latch operands, iterate, publish the corrected result.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= 5'd0;
      op_q  <= 2'd0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      acc_q <= 33'd0;
      q_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      dbz_q <= 1'b0;
    end else if (!eflush) begin
      case (state_q)
        S_IDLE: begin
          if (estart) begin
            op_q  <= eop;
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            dz_q  <= start_dz;
            cnt_q <= 5'd31;
            dbz_q <= 1'b0;
            if (start_dz) begin
              acc_q <= {1'b0, ea};
              q_q   <= 32'hFFFF_FFFF;
              b_q   <= 32'd0;
            end else if (eop[1]) begin
              acc_q <= 33'd0;
              q_q   <= a_mag;
              b_q   <= b_mag;
            end else begin
              acc_q <= 33'd0;
              q_q   <= b_mag;
              b_q   <= a_mag;
            end
          end
        end
        S_RUN: begin
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
          if (op_q[1]) begin
            acc_q <= div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
            q_q   <= {q_q[30:0], div_ge};
          end else begin
            acc_q <= {1'b0, mul_sum[32:1]};
            q_q   <= {mul_sum[0], q_q[31:1]};
          end
        end
        S_FIX: begin
          hi_q  <= fix_res[63:32];
          lo_q  <= fix_res[31:0];
          dbz_q <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbz         = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Self-checking bench for pipe_exe_muldiv: directed corner cases plus
// randomized operations against a plain-arithmetic reference model.
module tb_pipe_exe_muldiv;

  logic        clock = 1'b0;
  logic        resetn;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea, eb;
  logic        eflush;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_hi, last_lo;
  logic        last_dbz;

  pipe_exe_muldiv dut (
    .clock       (clock),
    .resetn      (resetn),
    .estart      (estart),
    .eop         (eop),
    .ea          (ea),
    .eb          (eb),
    .eflush      (eflush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .dbz         (dbz),
    .dbg_state_o (dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dbz);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    e_dbz = 1'b0;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b01: begin
        sx = longint'($signed(a)); sy = longint'($signed(b));
        p = 64'(sx * sy); e_hi = p[63:32]; e_lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e_hi = a; e_lo = 32'hFFFF_FFFF; e_dbz = 1'b1;
        end else if (op == 2'b10) begin
          e_lo = a / b; e_hi = a % b;
        end else begin
          sx = longint'($signed(a)); sy = longint'($signed(b));
          sq = sx / sy; sr = sx % sy;
          e_lo = sq[31:0]; e_hi = sr[31:0];
        end
      end
    endcase
  endtask

  // Issue one operation and check latency, busy length, result and done pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit mid_start);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz;
    int n, bc, e_lat;
    model(op, a, b, e_hi, e_lo, e_dbz);
    e_lat = (op[1] && b == 32'd0) ? 2 : 34;
    estart = 1'b1; eop = op; ea = a; eb = b;
    @(posedge clock); #1;
    estart = 1'b0;
    n = 1; bc = 0;
    check({tag, "_dbz_cleared"}, {63'd0, dbz}, 64'd0);
    while (!done && n < 100) begin
      if (busy) bc++;
      if (mid_start && n == 5) begin
        estart = 1'b1; eop = ~op; ea = ~a; eb = b + 32'd3;
      end else begin
        estart = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    estart = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(e_lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(e_lat - 1));
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, {e_hi, e_lo});
    check({tag, "_dbz"}, {63'd0, dbz}, {63'd0, e_dbz});
    @(posedge clock); #1;
    check({tag, "_done_single"}, {63'd0, done}, 64'd0);
    last_hi = e_hi; last_lo = e_lo; last_dbz = e_dbz;
  endtask

  initial begin
    int n;
    resetn = 1'b0; estart = 1'b0; eop = 2'd0; ea = 32'd0; eb = 32'd0; eflush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, dbz}, 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Directed cases.
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_m7x3", 2'b01, 32'hFFFF_FFF9, 32'd3, 1'b0);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_dbz", 2'b10, 32'd100, 32'd0, 1'b0);
    run_op("multu_after_dbz", 2'b00, 32'd12345, 32'd678, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("div_dbz_signed", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("divu_ignore_mid", 2'b10, 32'd1000003, 32'd97, 1'b1);

    // estart together with eflush in IDLE must not start.
    estart = 1'b1; eflush = 1'b1; eop = 2'b00; ea = 32'd5; eb = 32'd6;
    @(posedge clock); #1;
    estart = 1'b0; eflush = 1'b0;
    check("flush_beats_start", {63'd0, busy}, 64'd0);

    // Flush at RUN cycle 10: back to IDLE, no done, result unchanged.
    estart = 1'b1; eop = 2'b01; ea = 32'h1234_5678; eb = 32'h8765_4321;
    @(posedge clock); #1;
    estart = 1'b0;
    for (int i = 1; i < 10; i++) begin @(posedge clock); #1; end
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    eflush = 1'b1;
    @(posedge clock); #1;
    eflush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n++;
      @(posedge clock); #1;
    end
    check("flush_no_done", 64'(n), 64'd0);
    check("flush_hilo_kept", {hi, lo}, {last_hi, last_lo});
    check("flush_dbz_kept", {63'd0, dbz}, {63'd0, last_dbz});

    // Reset during FIX clears everything.
    estart = 1'b1; eop = 2'b10; ea = 32'd1000; eb = 32'd7;
    @(posedge clock); #1;
    estart = 1'b0;
    for (int i = 1; i < 33; i++) begin @(posedge clock); #1; end
    check("fix_reached_busy", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("rst_fix_hilo", {hi, lo}, 64'd0);
    check("rst_fix_flags", {61'd0, busy, done, dbz}, 64'd0);
    resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n++;
      @(posedge clock); #1;
    end
    check("rst_fix_no_done", 64'(n), 64'd0);
    run_op("divu_17_5", 2'b10, 32'd17, 32'd5, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op("random", r_op, r_a, r_b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
